// File: rtl/lsq_fwd.sv
// lsq_fwd: load/store queue with store-to-load forwarding.
//
// Loads and stores sit in separate circular queues. Stores are committed in ROB order and
// committed stores drain to data memory one per cycle. Loads are serviced in order. Each load
// searches the stores that were older than it (captured as an SQ tail snapshot at issue) and
// forwards the youngest address match. Otherwise it reads memory. Results go back to the ROB.
// Flush discards all speculative (uncommitted) state.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   issue_*             op issue (valid/ready, load/store select, rob tag, address, store data)
//   commit_store/rob    in-order store commit from the ROB
//   flush               discard LQ and uncommitted stores
//   wb_*                load writeback (1-cycle pulse)
//   mem_rd_*            data-memory read request/response (one outstanding)
//   mem_wr_*            data-memory write (store drain)
//   commit_err          sticky: a commit tag did not match the oldest uncommitted store
module lsq_fwd #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ROB_IDX_W = 5,
  parameter int unsigned LQ_DEPTH  = 8,
  parameter int unsigned SQ_DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic                 issue_is_load,
  input  logic                 issue_is_store,
  input  logic [ROB_IDX_W-1:0] issue_rob,
  input  logic [DATA_W-1:0]    issue_addr,
  input  logic [DATA_W-1:0]    issue_store_data,
  input  logic                 commit_store,
  input  logic [ROB_IDX_W-1:0] commit_rob,
  input  logic                 flush,
  output logic                 wb_valid,
  output logic [ROB_IDX_W-1:0] wb_rob,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 mem_rd_valid,
  output logic [DATA_W-1:0]    mem_rd_addr,
  input  logic                 mem_rd_resp,
  input  logic [DATA_W-1:0]    mem_rd_data,
  output logic                 mem_wr_valid,
  output logic [DATA_W-1:0]    mem_wr_addr,
  output logic [DATA_W-1:0]    mem_wr_data,
  output logic                 commit_err
);

  localparam int unsigned LQ_AW = $clog2(LQ_DEPTH);
  localparam int unsigned SQ_AW = $clog2(SQ_DEPTH);
  localparam int unsigned LQ_PW = LQ_AW + 1;
  localparam int unsigned SQ_PW = SQ_AW + 1;

  typedef enum logic [1:0] {LIdle, LWait, LWb} lstate_e;

  // Store queue storage and pointers. Committed entries always form a prefix starting at
  // the head, so sq_cmt_q (oldest uncommitted entry) replaces per-entry committed bits.
  logic [ROB_IDX_W-1:0] sq_rob_q  [SQ_DEPTH];
  logic [DATA_W-1:0]    sq_addr_q [SQ_DEPTH];
  logic [DATA_W-1:0]    sq_data_q [SQ_DEPTH];
  logic [SQ_PW-1:0]     sq_head_q, sq_cmt_q, sq_tail_q;

  // Load queue storage and pointers.
  logic [ROB_IDX_W-1:0] lq_rob_q  [LQ_DEPTH];
  logic [DATA_W-1:0]    lq_addr_q [LQ_DEPTH];
  logic [SQ_PW-1:0]     lq_snap_q [LQ_DEPTH];
  // Set once the SQ head has moved past an entry's snapshot: its forwarding window is empty.
  logic [LQ_DEPTH-1:0]  lq_stale_q;
  logic [LQ_PW-1:0]     lq_head_q, lq_tail_q;

  lstate_e              state_q;
  logic                 drop_resp_q;
  logic [ROB_IDX_W-1:0] wb_rob_q;
  logic [DATA_W-1:0]    wb_data_q;
  logic                 commit_err_q;

  logic [LQ_AW-1:0]     lq_hidx, lq_tidx;
  logic [SQ_AW-1:0]     sq_tidx, sq_cidx, sq_hidx;
  logic                 sq_full, lq_full, lq_empty;
  logic                 push_ld, push_st, sq_drain, cmt_ok, cmt_bad, lq_pop;
  logic [SQ_PW-1:0]     win_len;
  logic [SQ_AW-1:0]     fwd_idx;
  logic                 fwd_hit;
  logic [DATA_W-1:0]    fwd_data;

  assign lq_hidx = lq_head_q[LQ_AW-1:0];
  assign lq_tidx = lq_tail_q[LQ_AW-1:0];
  assign sq_hidx = sq_head_q[SQ_AW-1:0];
  assign sq_tidx = sq_tail_q[SQ_AW-1:0];
  assign sq_cidx = sq_cmt_q[SQ_AW-1:0];

  assign sq_full  = (sq_tail_q[SQ_AW] != sq_head_q[SQ_AW]) && (sq_tidx == sq_hidx);
  assign lq_full  = (lq_tail_q[LQ_AW] != lq_head_q[LQ_AW]) && (lq_tidx == lq_hidx);
  assign lq_empty = (lq_head_q == lq_tail_q);

  // Loads take precedence when both op flags are set.
  assign issue_ready = issue_is_load  ? !lq_full :
                       issue_is_store ? !sq_full : 1'b1;
  assign push_ld = issue_valid && issue_ready && issue_is_load && !flush;
  assign push_st = issue_valid && issue_ready && !issue_is_load && issue_is_store && !flush;

  assign sq_drain = (sq_head_q != sq_cmt_q);
  assign cmt_ok   = commit_store && !flush && (sq_cmt_q != sq_tail_q) &&
                    (sq_rob_q[sq_cidx] == commit_rob);
  assign cmt_bad  = commit_store && !flush && !cmt_ok;
  assign lq_pop   = (state_q == LWb) && !flush;

  // Forwarding window [sq_head, snap) for the LQ head. Scanning oldest to youngest lets the
  // youngest match win.
  assign win_len = lq_stale_q[lq_hidx] ? '0 : (lq_snap_q[lq_hidx] - sq_head_q);

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned k = 0; k < SQ_DEPTH; k++) begin
      fwd_idx = sq_hidx + SQ_AW'(k);
      if ((SQ_PW'(k) < win_len) && (sq_addr_q[fwd_idx] == lq_addr_q[lq_hidx])) begin
        fwd_hit  = 1'b1;
        fwd_data = sq_data_q[fwd_idx];
      end
    end
  end

  assign mem_rd_valid = (state_q == LIdle) && !lq_empty && !fwd_hit && !drop_resp_q && !flush;
  assign mem_rd_addr  = mem_rd_valid ? lq_addr_q[lq_hidx] : '0;
  assign mem_wr_valid = sq_drain;
  assign mem_wr_addr  = sq_drain ? sq_addr_q[sq_hidx] : '0;
  assign mem_wr_data  = sq_drain ? sq_data_q[sq_hidx] : '0;
  assign wb_valid     = (state_q == LWb) && !flush;
  assign wb_rob       = wb_rob_q;
  assign wb_data      = wb_data_q;
  assign commit_err   = commit_err_q;

  // Queue pointers and sticky commit error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq_head_q    <= '0;
      sq_cmt_q     <= '0;
      sq_tail_q    <= '0;
      lq_head_q    <= '0;
      lq_tail_q    <= '0;
      commit_err_q <= 1'b0;
    end else begin
      if (sq_drain) sq_head_q <= sq_head_q + SQ_PW'(1);
      if (cmt_ok)   sq_cmt_q  <= sq_cmt_q + SQ_PW'(1);
      if (cmt_bad)  commit_err_q <= 1'b1;
      if (flush) begin
        // Keep only committed stores; they still drain.
        sq_tail_q <= sq_cmt_q;
        lq_tail_q <= lq_head_q;
      end else begin
        if (push_st) sq_tail_q <= sq_tail_q + SQ_PW'(1);
        if (push_ld) lq_tail_q <= lq_tail_q + LQ_PW'(1);
        if (lq_pop)  lq_head_q <= lq_head_q + LQ_PW'(1);
      end
    end
  end

  // Queue payload storage; contents are only meaningful between head and tail.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
      // Draining the entry at a snapshot moves the head past it.
      if (sq_drain && (lq_snap_q[LQ_AW'(i)] == sq_head_q)) lq_stale_q[LQ_AW'(i)] <= 1'b1;
    end
    if (push_ld) begin
      lq_rob_q[lq_tidx]   <= issue_rob;
      lq_addr_q[lq_tidx]  <= issue_addr;
      lq_snap_q[lq_tidx]  <= sq_tail_q;
      lq_stale_q[lq_tidx] <= 1'b0;
    end
    if (push_st) begin
      sq_rob_q[sq_tidx]  <= issue_rob;
      sq_addr_q[sq_tidx] <= issue_addr;
      sq_data_q[sq_tidx] <= issue_store_data;
    end
  end

  // Load service FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LIdle;
      drop_resp_q <= 1'b0;
      wb_rob_q    <= '0;
      wb_data_q   <= '0;
    end else begin
      if (drop_resp_q && mem_rd_resp) drop_resp_q <= 1'b0;
      if (flush) begin
        state_q <= LIdle;
        // The abandoned read's response is still coming and must be swallowed.
        if ((state_q == LWait) && !mem_rd_resp) drop_resp_q <= 1'b1;
      end else begin
        unique case (state_q)
          LIdle: begin
            if (!lq_empty) begin
              if (fwd_hit) begin
                wb_rob_q  <= lq_rob_q[lq_hidx];
                wb_data_q <= fwd_data;
                state_q   <= LWb;
              end else if (!drop_resp_q) begin
                wb_rob_q <= lq_rob_q[lq_hidx];
                state_q  <= LWait;
              end
            end
          end
          LWait: begin
            if (mem_rd_resp) begin
              wb_data_q <= mem_rd_data;
              state_q   <= LWb;
            end
          end
          LWb:     state_q <= LIdle;
          default: state_q <= LIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsq_fwd.sv
// Scoreboard bench for lsq_fwd: directed stimulus pushes expected writebacks, memory reads and
// memory writes into queues; a negedge monitor pops and compares whenever the DUT presents one.
module tb_lsq_fwd;

  logic        clk, rst;
  logic        issue_valid, issue_ready, issue_is_load, issue_is_store;
  logic [4:0]  issue_rob, commit_rob, wb_rob;
  logic [31:0] issue_addr, issue_store_data, wb_data;
  logic        commit_store, flush, wb_valid;
  logic        mem_rd_valid, mem_rd_resp, mem_wr_valid, commit_err;
  logic [31:0] mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;

  lsq_fwd #(.DATA_W(32), .ROB_IDX_W(5), .LQ_DEPTH(8), .SQ_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_is_load(issue_is_load), .issue_is_store(issue_is_store),
    .issue_rob(issue_rob), .issue_addr(issue_addr), .issue_store_data(issue_store_data),
    .commit_store(commit_store), .commit_rob(commit_rob), .flush(flush),
    .wb_valid(wb_valid), .wb_rob(wb_rob), .wb_data(wb_data),
    .mem_rd_valid(mem_rd_valid), .mem_rd_addr(mem_rd_addr),
    .mem_rd_resp(mem_rd_resp), .mem_rd_data(mem_rd_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .commit_err(commit_err)
  );

  typedef struct {logic [4:0] rob; logic [31:0] data; int at;} wb_exp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_exp_t;

  wb_exp_t     exp_wb[$];
  wr_exp_t     exp_wr[$];
  logic [31:0] exp_rd[$];
  wb_exp_t     mon_wb;
  wr_exp_t     mon_wr;
  logic [31:0] mon_rd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_lat = 3;
  int at;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h40:  return 32'h55;
      32'h20:  return 32'h77;
      32'h30:  return 32'h66;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor.
  always @(negedge clk) begin
    if (rst) begin
      if (wb_valid) begin
        if (exp_wb.size() == 0) chk("wb_unexpected", wb_valid, 1'b0);
        else begin
          mon_wb = exp_wb.pop_front();
          chk("wb_rob", wb_rob, mon_wb.rob);
          chk("wb_data", wb_data, mon_wb.data);
          if (mon_wb.at >= 0) chk("wb_cycle", cyc, mon_wb.at);
        end
      end
      if (mem_rd_valid) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", mem_rd_valid, 1'b0);
        else begin
          mon_rd = exp_rd.pop_front();
          chk("rd_addr", mem_rd_addr, mon_rd);
        end
      end
      if (mem_wr_valid) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", mem_wr_valid, 1'b0);
        else begin
          mon_wr = exp_wr.pop_front();
          chk("wr_addr", mem_wr_addr, mon_wr.addr);
          chk("wr_data", mem_wr_data, mon_wr.data);
        end
      end
    end
  end

  // Memory read responder: one outstanding read, response rd_lat cycles after the request.
  initial begin
    logic [31:0] a;
    mem_rd_resp = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(negedge clk);
      if (rst && mem_rd_valid) begin
        a = mem_rd_addr;
        repeat (rd_lat) @(posedge clk);
        #1;
        mem_rd_resp = 1'b1;
        mem_rd_data = mem_val(a);
        @(posedge clk);
        #1;
        mem_rd_resp = 1'b0;
        mem_rd_data = '0;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue_st(input logic [4:0] rob, input logic [31:0] addr, input logic [31:0] d);
    issue_valid = 1'b1; issue_is_store = 1'b1; issue_is_load = 1'b0;
    issue_rob = rob; issue_addr = addr; issue_store_data = d;
    #1 chk("issue_ready_store", issue_ready, 1'b1);
    @(posedge clk); #1;
    issue_valid = 1'b0; issue_is_store = 1'b0;
  endtask

  task automatic issue_ld(input logic [4:0] rob, input logic [31:0] addr);
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_is_store = 1'b0;
    issue_rob = rob; issue_addr = addr;
    #1 chk("issue_ready_load", issue_ready, 1'b1);
    @(posedge clk); #1;
    issue_valid = 1'b0; issue_is_load = 1'b0;
  endtask

  task automatic commit(input logic [4:0] rob);
    commit_store = 1'b1; commit_rob = rob;
    @(posedge clk); #1;
    commit_store = 1'b0;
  endtask

  initial begin
    rst = 1'b0; issue_valid = 0; issue_is_load = 0; issue_is_store = 0;
    issue_rob = 0; issue_addr = 0; issue_store_data = 0;
    commit_store = 0; commit_rob = 0; flush = 0;
    #2;
    chk("rst_issue_ready", issue_ready, 1'b1);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_mem_rd_valid", mem_rd_valid, 1'b0);
    chk("rst_mem_wr_valid", mem_wr_valid, 1'b0);
    chk("rst_commit_err", commit_err, 1'b0);
    chk("rst_wb_data", wb_data, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    // Forward from a single older store: writeback two cycles after load issue.
    issue_st(5'd3, 32'h10, 32'hAA);
    exp_wb.push_back('{rob: 5'd4, data: 32'hAA, at: cyc + 2});
    issue_ld(5'd4, 32'h10);
    idle(4);
    exp_wr.push_back('{addr: 32'h10, data: 32'hAA});
    commit(5'd3);
    idle(3);

    // Youngest of two matching stores wins.
    issue_st(5'd5, 32'h20, 32'h1);
    issue_st(5'd6, 32'h20, 32'h2);
    exp_wb.push_back('{rob: 5'd7, data: 32'h2, at: cyc + 2});
    issue_ld(5'd7, 32'h20);
    idle(3);
    exp_wr.push_back('{addr: 32'h20, data: 32'h1});
    exp_wr.push_back('{addr: 32'h20, data: 32'h2});
    commit(5'd5);
    commit(5'd6);
    idle(3);

    // Load older than a later store to the same address reads memory.
    exp_rd.push_back(32'h20);
    exp_wb.push_back('{rob: 5'd8, data: 32'h77, at: cyc + 2 + rd_lat});
    issue_ld(5'd8, 32'h20);
    issue_st(5'd9, 32'h20, 32'h3);
    idle(8);
    exp_wr.push_back('{addr: 32'h20, data: 32'h3});
    commit(5'd9);
    idle(3);

    // Memory load with 3-cycle latency, then a load whose older store drained past its snapshot
    // while a younger store to the same address still sits in the array.
    issue_st(5'd10, 32'h30, 32'h33);
    exp_rd.push_back(32'h40);
    exp_wb.push_back('{rob: 5'd11, data: 32'h55, at: cyc + 2 + rd_lat});
    issue_ld(5'd11, 32'h40);
    exp_rd.push_back(32'h30);
    exp_wb.push_back('{rob: 5'd12, data: 32'h66, at: -1});
    issue_ld(5'd12, 32'h30);
    issue_st(5'd13, 32'h30, 32'h3D);
    exp_wr.push_back('{addr: 32'h30, data: 32'h33});
    exp_wr.push_back('{addr: 32'h30, data: 32'h3D});
    commit(5'd10);
    commit(5'd13);
    idle(10);

    // Fill the store queue, then drain it one store per cycle.
    for (int i = 0; i < 8; i++) issue_st(5'(16 + i), 32'h100 + i, 32'h1000 + i);
    issue_is_store = 1'b1;
    #1 chk("full_ready_store", issue_ready, 1'b0);
    issue_is_store = 1'b0; issue_is_load = 1'b1;
    #1 chk("full_ready_load", issue_ready, 1'b1);
    issue_is_load = 1'b0; issue_is_store = 1'b1;
    for (int i = 0; i < 8; i++) exp_wr.push_back('{addr: 32'h100 + i, data: 32'h1000 + i});
    for (int i = 0; i < 8; i++) begin
      commit_store = 1'b1; commit_rob = 5'(16 + i);
      @(negedge clk);
      if (i < 2) chk("drain_ready_still_full", issue_ready, 1'b0);
      if (i == 2) chk("drain_ready_returns", issue_ready, 1'b1);
      if (i >= 1) chk("drain_every_cycle", mem_wr_valid, 1'b1);
      @(posedge clk); #1;
    end
    commit_store = 1'b0;
    @(negedge clk);
    chk("drain_last", mem_wr_valid, 1'b1);
    @(posedge clk); #1;
    issue_is_store = 1'b0;
    idle(2);

    // Mismatched commit tag.
    chk("commit_err_clear", commit_err, 1'b0);
    issue_st(5'd5, 32'h50, 32'h5);
    commit(5'd7);
    chk("commit_err_set", commit_err, 1'b1);
    idle(2);
    exp_wr.push_back('{addr: 32'h50, data: 32'h5});
    commit(5'd5);
    idle(2);
    chk("commit_err_sticky", commit_err, 1'b1);

    // Flush during a memory read with two committed and two uncommitted stores.
    rd_lat = 6;
    issue_st(5'd20, 32'h60, 32'h60);
    issue_st(5'd21, 32'h61, 32'h61);
    issue_st(5'd22, 32'h62, 32'h62);
    issue_st(5'd23, 32'h63, 32'h63);
    exp_rd.push_back(32'h70);
    issue_ld(5'd24, 32'h70);
    exp_wr.push_back('{addr: 32'h60, data: 32'h60});
    exp_wr.push_back('{addr: 32'h61, data: 32'h61});
    commit(5'd20);
    commit(5'd21);
    // Commit and issue in the flush cycle must be ignored.
    flush = 1'b1; commit_store = 1'b1; commit_rob = 5'd22;
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rob = 5'd26; issue_addr = 32'h90;
    @(posedge clk); #1;
    flush = 1'b0; commit_store = 1'b0; issue_valid = 1'b0; issue_is_load = 1'b0;
    // New read waits for the dropped response.
    exp_rd.push_back(32'h62);
    exp_wb.push_back('{rob: 5'd25, data: mem_val(32'h62), at: cyc + 11});
    issue_ld(5'd25, 32'h62);
    idle(16);
    chk("flush_sq_idle", mem_wr_valid, 1'b0);

    // Asynchronous reset in the middle of a drain.
    rd_lat = 3;
    issue_st(5'd30, 32'h80, 32'h80);
    issue_st(5'd31, 32'h81, 32'h81);
    exp_wr.push_back('{addr: 32'h80, data: 32'h80});
    commit(5'd30);
    commit(5'd31);
    chk("mid_drain_wr_valid", mem_wr_valid, 1'b1);
    chk("mid_drain_wr_addr", mem_wr_addr, 32'h81);
    rst = 1'b0;
    #1;
    chk("async_rst_wr_valid", mem_wr_valid, 1'b0);
    chk("async_rst_wr_addr", mem_wr_addr, 32'h0);
    chk("async_rst_commit_err", commit_err, 1'b0);
    chk("async_rst_issue_ready", issue_ready, 1'b1);
    chk("async_rst_wb_valid", wb_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);
    chk("post_rst_sq_empty", mem_wr_valid, 1'b0);

    chk("wb_queue_drained", exp_wb.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    chk("wr_queue_drained", exp_wr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsq_fwd.md
Name: lsq_fwd

Overview:
Parametrised load/store queue that replaces the single-entry LSU in the out-of-order core. It holds issued loads and stores in separate circular queues, commits stores in ROB order, and drains committed stores to data memory. Loads are serviced in order, with youngest-older-store forwarding; loads that miss forwarding read memory. Load results are written back to the ROB. Pipeline flush discards all speculative state.

Parameters:
DATA_W, 32, data and address width
ROB_IDX_W, 5, ROB tag width
LQ_DEPTH, 8, load queue entries (power of 2, >=2)
SQ_DEPTH, 8, store queue entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
issue_valid  in  1  issue request
issue_ready  out  1  target queue has space (registered-count based)
issue_is_load  in  1  load op
issue_is_store  in  1  store op
issue_rob  in  ROB_IDX_W  ROB tag
issue_addr  in  DATA_W  word address
issue_store_data  in  DATA_W  store data
commit_store  in  1  ROB commits a store
commit_rob  in  ROB_IDX_W  committing store tag
flush  in  1  drop all uncommitted state
wb_valid  out  1  load result valid (1-cycle pulse)
wb_rob  out  ROB_IDX_W  load tag
wb_data  out  DATA_W  load data
mem_rd_valid  out  1  read request (1-cycle pulse)
mem_rd_addr  out  DATA_W  read address
mem_rd_resp  in  1  read data valid (any latency >=1, one outstanding)
mem_rd_data  in  DATA_W  read data
mem_wr_valid  out  1  write enable
mem_wr_addr  out  DATA_W  write address
mem_wr_data  out  DATA_W  write data
commit_err  out  1  sticky: commit_rob mismatched oldest uncommitted store

Behaviour:
- Reset (rst=0, async): queues empty, all pointers 0, FSM L_IDLE, every output 0 except issue_ready=1.
- issue_ready = !lq_full when issue_is_load; !sq_full when issue_is_store. It is computed from registered counts, so a pop in the same cycle never frees a slot. Push occurs on issue_valid & issue_ready. is_load and is_store are never both set; if both are set, treat the op as a load.
- Load push records rob, addr, and sq_snap = SQ tail pointer including wrap bit (ptr width log2(SQ_DEPTH)+1).
- Store push records rob, addr, data, committed=0.
- Commit: on commit_store, mark the oldest uncommitted SQ entry committed if its rob equals commit_rob. Otherwise ignore the commit and set commit_err, which holds until reset. Commits arrive at most one per cycle.
- Drain: if the SQ head entry is committed, assert mem_wr_valid with its addr/data and pop the head in the same cycle. Throughput is one store per cycle.
- Load FSM:
  - L_IDLE: if LQ is non-empty, search SQ entries in [sq_head, head_load.sq_snap) on registered state, including an entry draining this cycle. On an address match, take the youngest matching entry's data and go to L_WB. On no match, pulse mem_rd_valid with addr and go to L_WAIT.
  - L_WAIT: on mem_rd_resp, capture data and go to L_WB.
  - L_WB: wb_valid=1 with rob/data, pop the LQ head, go to L_IDLE.
- Latency: forwarded load issued in cycle 0 writes back in cycle 2. Memory load writes back 1 cycle after mem_rd_resp.
- Snapshot stale case: if sq_head has passed sq_snap (all older stores drained), the window is empty and no forward occurs.
- Flush (sync, highest priority):
  - LQ emptied.
  - SQ tail set to head + number of committed entries.
  - FSM goes to L_IDLE. wb_valid is suppressed that cycle.
  - If flush occurs in L_WAIT, set drop_resp. The next mem_rd_resp is consumed silently and no new read issues until it arrives.
  - Issue and commit in the flush cycle are ignored. Drain continues.
- Full and empty are distinguished by the pointer wrap bit. Pointers wrap modulo depth.

Test Plan:
- Store rob=3 addr=0x10 data=0xAA, then load rob=4 addr=0x10 -> wb_valid 2 cycles after load issue with wb_rob=4, wb_data=0xAA, no mem_rd_valid.
- Stores to 0x20 with data 0x1 then 0x2, then load 0x20 -> wb_data=0x2 (youngest older store). A load issued before a later store to 0x20 reads memory instead.
- Load 0x40 with memory returning 0x55 after 3 cycles -> one mem_rd_valid pulse with addr 0x40, then wb_valid one cycle after resp with data 0x55.
- Fill SQ with SQ_DEPTH stores -> issue_ready=0 for stores and 1 for loads. Commit rob tags in order -> one mem_wr_valid per cycle in order, and ready returns the cycle after the first drain.
- Commit with commit_rob=7 while the oldest uncommitted store is rob=5 -> entry stays uncommitted, commit_err=1 until reset.
- Flush during L_WAIT with 2 committed and 2 uncommitted stores -> late resp produces no wb, 2 stores are written to memory, SQ ends empty. Async reset mid-drain clears all outputs immediately.
